// File: rtl/vga_pattern_gen_pkg.sv
// vga_pattern_gen_pkg: shared encodings for the VGA test-pattern source.
//   mode_e     : pattern-mode encodings (bars / checker / gradient / solid)
//   chan_e     : colour-channel indices R/G/B
//   NUM_PHASES : number of rotating colour phases
//   lit_chan() : (phase + sector) mod 3 -> lit channel
package vga_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  localparam int NUM_PHASES = 3;

  // Sum is at most 2 + 15, so a 6-bit mod-3 suffices.
  function automatic chan_e lit_chan(input logic [1:0] phase, input logic [3:0] sector);
    logic [5:0] sum;
    logic [5:0] m;
    sum = {4'b0, phase} + {2'b0, sector};
    m   = sum % 6'd3;
    return chan_e'(m[1:0]);
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: pixel bus between timing generator, pattern source and DAC.
//   col/row/active         : timing generator -> pattern source
//   red/green/blue/pix_valid: pattern source -> DAC (registered, 1-cycle latency)
//   master modport: drives timing, consumes pixels; slave modport: the pattern source.
interface vga_pattern_gen_if #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 8
);
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic               active;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               pix_valid;

  modport master (output col, row, active, input red, green, blue, pix_valid);
  modport slave  (input col, row, active, output red, green, blue, pix_valid);
endinterface

// File: rtl/vga_pattern_gen_step_tick_gen.sv
// step_tick_gen: free-running 0..TICKS_PER_STEP-1 counter.
//   i_clk   : pixel clock
//   i_reset : synchronous active-low reset (counter -> 0)
//   o_tick  : high during the cycle the counter wraps (count == TICKS_PER_STEP-1)
module step_tick_gen #(
  parameter int TICKS_PER_STEP = 25_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);
  localparam int CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset)    r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA test-pattern source.
//   i_clk, i_reset : pixel clock, synchronous active-low reset
//   bus (slave)    : col/row/active in, red/green/blue/pix_valid out (1-cycle latency)
//   i_mode         : 0 bars, 1 checker, 2 gradient, 3 solid (latched at frame start)
//   i_freeze       : discard step ticks (phase holds)
//   o_phase        : current colour phase 0..2
// Colour phase and mode only change at frame start, so a frame never tears.
module vga_pattern_gen
  import vga_pattern_gen_pkg::*;
#(
  parameter int COLOR_W        = 8,
  parameter int COORD_W        = 10,
  parameter int H_ACTIVE       = 640,
  parameter int NUM_SECTORS    = 4,
  parameter int CELL_H_LOG2    = 6,
  parameter int TICKS_PER_STEP = 25_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  vga_pattern_gen_if.slave   bus,
  input  logic [1:0]         i_mode,
  input  logic               i_freeze,
  output logic [1:0]         o_phase
);
  localparam int SEC_W = H_ACTIVE / NUM_SECTORS;
  localparam int KW    = (SEC_W > 1) ? $clog2(SEC_W) : 1;
  localparam logic [KW-1:0]      K_LAST = KW'(SEC_W - 1);
  localparam logic [3:0]         S_LAST = 4'(NUM_SECTORS - 1);
  localparam logic [COLOR_W-1:0] FS     = '1;

  // ---------------- step tick ----------------
  logic w_tick;
  step_tick_gen #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_tick (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (w_tick)
  );

  // ---------------- frame-start / phase ----------------
  logic       w_sof, w_step;
  logic       r_pending, w_pending_nxt;
  logic [1:0] r_phase, w_phase_nxt;
  mode_e      r_mode_q, w_mode_nxt;

  assign w_sof  = bus.active && (bus.col == '0) && (bus.row == '0);
  assign w_step = w_tick && !i_freeze;

  // A wrap coinciding with SOF advances immediately rather than via pending.
  always_comb begin
    w_phase_nxt   = r_phase;
    w_pending_nxt = r_pending;
    w_mode_nxt    = r_mode_q;
    if (w_sof) begin
      w_mode_nxt    = mode_e'(i_mode);
      w_pending_nxt = 1'b0;
      if (r_pending || w_step)
        w_phase_nxt = (r_phase == 2'(NUM_PHASES - 1)) ? 2'd0 : r_phase + 2'd1;
    end else if (w_step) begin
      w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_phase   <= 2'd0;
      r_pending <= 1'b0;
      r_mode_q  <= MODE_BARS;
    end else begin
      r_phase   <= w_phase_nxt;
      r_pending <= w_pending_nxt;
      r_mode_q  <= w_mode_nxt;
    end
  end

  assign o_phase = r_phase;

  // ---------------- sector tracking (no divider) ----------------
  // Counters restart on col==0; the effective values feed this cycle's colour.
  logic [KW-1:0] r_k, w_k;
  logic [3:0]    r_s, w_s;

  assign w_k = (bus.col == '0) ? '0 : r_k;
  assign w_s = (bus.col == '0) ? '0 : r_s;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_k <= '0;
      r_s <= '0;
    end else if (bus.active && (w_k == K_LAST)) begin
      r_k <= '0;
      r_s <= (w_s == S_LAST) ? w_s : w_s + 4'd1;
    end else if (bus.active) begin
      r_k <= w_k + 1'b1;
      r_s <= w_s;
    end else begin
      r_k <= w_k;
      r_s <= w_s;
    end
  end

  // ---------------- colour mux ----------------
  logic [COLOR_W-1:0] w_grad;
  generate
    if (COLOR_W <= COORD_W) begin : g_grad_trunc
      assign w_grad = bus.col[COORD_W-1 -: COLOR_W];
    end else begin : g_grad_ext
      assign w_grad = {bus.col, {(COLOR_W-COORD_W){1'b0}}};
    end
  endgenerate

  chan_e              w_lit, w_sel;
  logic               w_white;
  logic [COLOR_W-1:0] w_val, w_r, w_g, w_b;

  // Checkerboard alternates on sector parity vs. the cell-row bit.
  assign w_white = w_s[0] ^ bus.row[CELL_H_LOG2];
  assign w_lit   = lit_chan(w_phase_nxt, w_s);

  always_comb begin
    w_sel = w_lit;
    w_val = FS;
    case (w_mode_nxt)
      MODE_GRAD:  w_val = w_grad;
      MODE_SOLID: w_sel = chan_e'(w_phase_nxt);
      default:    ;
    endcase
    w_r = (w_sel == CH_R) ? w_val : '0;
    w_g = (w_sel == CH_G) ? w_val : '0;
    w_b = (w_sel == CH_B) ? w_val : '0;
    if (w_mode_nxt == MODE_CHECK && w_white) begin
      w_r = FS;
      w_g = FS;
      w_b = FS;
    end
  end

  // ---------------- output register ----------------
  logic [COLOR_W-1:0] r_red, r_green, r_blue;
  logic               r_pix_valid;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_red       <= bus.active ? w_r : '0;
      r_green     <= bus.active ? w_g : '0;
      r_blue      <= bus.active ? w_b : '0;
      r_pix_valid <= bus.active;
    end
  end

  assign bus.red       = r_red;
  assign bus.green     = r_green;
  assign bus.blue      = r_blue;
  assign bus.pix_valid = r_pix_valid;

  logic w_unused;
  assign w_unused = ^{bus.row, bus.col};
endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;
  localparam int COLOR_W = 8, COORD_W = 10, H_ACT = 16, NSEC = 4, CELL = 1, TICKS = 10;
  localparam int SECW = H_ACT / NSEC;
  localparam int H_TOT = 20, V_ACT = 4, V_TOT = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic       freeze;
  logic [1:0] phase;
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  vga_pattern_gen_if #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) bus ();

  vga_pattern_gen #(
    .COLOR_W(COLOR_W), .COORD_W(COORD_W), .H_ACTIVE(H_ACT), .NUM_SECTORS(NSEC),
    .CELL_H_LOG2(CELL), .TICKS_PER_STEP(TICKS)
  ) dut (
    .i_clk(clk), .i_reset(reset_n), .bus(bus), .i_mode(mode), .i_freeze(freeze), .o_phase(phase)
  );

  // ---------------- behavioural model ----------------
  function automatic logic [23:0] pix(input int mq, input int ph, input int s, input int rb,
                                      input logic [9:0] c);
    int ch = (ph + s) % 3;
    logic [7:0] v = 8'hFF;
    if (mq == 1 && (((s % 2) ^ rb) == 1)) return 24'hFFFFFF;
    if (mq == 2) v = c[9:2];
    if (mq == 3) ch = ph;
    return {v, 16'h0} >> (8 * ch);
  endfunction

  bit known = 0;
  int m_cnt, m_pend, m_ph, m_mq, m_px;
  logic [23:0] e_rgb;
  logic        e_v;
  logic [1:0]  e_ph;

  always @(posedge clk) begin
    int idx, s;
    bit wrap, sof;
    if (!reset_n) begin
      known = 1; m_cnt = 0; m_pend = 0; m_ph = 0; m_mq = 0; m_px = 0;
      e_rgb = 24'h0; e_v = 1'b0;
    end else begin
      wrap  = (m_cnt == TICKS - 1);
      m_cnt = wrap ? 0 : m_cnt + 1;
      sof   = bus.active && bus.col == 0 && bus.row == 0;
      if (sof) begin
        m_mq = int'(mode);
        if (m_pend != 0 || (wrap && !freeze)) m_ph = (m_ph + 1) % 3;
        m_pend = 0;
      end else if (wrap && !freeze) m_pend = 1;
      idx  = (bus.col == 0) ? 0 : m_px;
      m_px = bus.active ? idx + 1 : idx;
      s    = idx / SECW;
      if (s > NSEC - 1) s = NSEC - 1;
      e_rgb = bus.active ? pix(m_mq, m_ph, s, int'(bus.row[CELL]), bus.col) : 24'h0;
      e_v   = bus.active;
    end
    e_ph = 2'(m_ph);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (known) begin
      n_assert++;
      if ({bus.red, bus.green, bus.blue, bus.pix_valid, phase} !== {e_rgb, e_v, e_ph}) begin
        n_fail++;
        $display("FAIL model t=%0t: got rgb=%h v=%b ph=%0d expected rgb=%h v=%b ph=%0d",
                 $time, {bus.red, bus.green, bus.blue}, bus.pix_valid, phase, e_rgb, e_v, e_ph);
      end
    end
  end

  task automatic lit(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [23:0] cap[V_TOT][H_TOT];
  logic [1:0]  ph_sof, ph_end;

  task automatic px(input int c, input int r, input bit a);
    bus.col = 10'(c); bus.row = 10'(r); bus.active = a;
    @(posedge clk); #1;
  endtask

  // frz: 0 off, 1 on, 2 random per cycle; chg>=0 changes mode mid-frame; rst_at>=0 pulses reset
  task automatic frame(input int md, input int frz, input int chg, input int rst_at);
    mode = 2'(md);
    for (int r = 0; r < V_TOT; r++)
      for (int c = 0; c < H_TOT; c++) begin
        if (chg >= 0 && r * H_TOT + c == 40) mode = 2'(chg);
        freeze  = (frz == 2) ? ($urandom_range(0, 3) == 0) : (frz == 1);
        reset_n = (r * H_TOT + c == rst_at) ? 1'b0 : 1'b1;
        px(c, r, (c < H_ACT) && (r < V_ACT));
        cap[r][c] = {bus.red, bus.green, bus.blue};
        if (r == 0 && c == 0) ph_sof = phase;
        if (r == V_ACT - 1 && c == H_ACT - 1) ph_end = phase;
      end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; mode = 2'd0; freeze = 1'b0;
    bus.col = '0; bus.row = '0; bus.active = 1'b1;
    for (int i = 0; i < 3; i++) px(0, 0, 1);
    lit("reset_rgb", {bus.red, bus.green, bus.blue}, 24'h0);
    lit("reset_valid", 24'(bus.pix_valid), 24'h0);
    lit("reset_phase", 24'(phase), 24'h0);
    reset_n = 1'b1;

    frame(0, 0, -1, -1);                       // F1: phase 0 bars
    lit("bars_s0_red",   cap[0][1],  24'hFF0000);
    lit("bars_s1_green", cap[0][5],  24'h00FF00);
    lit("bars_s2_blue",  cap[0][9],  24'h0000FF);
    lit("bars_s3_red",   cap[0][13], 24'hFF0000);
    lit("phase_held_midframe", 24'(ph_end), 24'h0);

    frame(0, 0, -1, -1);                       // F2: many wraps -> single step
    lit("phase_at_sof", 24'(ph_sof), 24'h1);
    lit("bars_ph1_s0_green", cap[0][1], 24'h00FF00);
    lit("collapse_wraps", 24'(ph_end), 24'h1);

    frame(0, 1, -1, -1);                       // F3: pending from F2 still consumed
    lit("freeze_keeps_pending", 24'(ph_sof), 24'h2);
    frame(0, 1, -1, -1);                       // F4: frozen wraps discarded
    lit("freeze_holds_phase", 24'(ph_sof), 24'h2);

    freeze = 1'b1;
    for (int i = 0; i < 9; i++) px(H_TOT, V_TOT, 0);  // align next SOF with a wrap

    frame(1, 0, 2, -1);                        // F5: wrap on SOF cycle, checker
    lit("wrap_on_sof", 24'(ph_sof), 24'h0);
    lit("chk_r0_s0", cap[0][1], 24'hFF0000);
    lit("chk_r0_s1", cap[0][5], 24'hFFFFFF);
    lit("chk_r1_s1", cap[1][5], 24'hFFFFFF);
    lit("chk_r2_s0", cap[2][1], 24'hFFFFFF);
    lit("chk_r2_s1", cap[2][5], 24'h00FF00);
    lit("chk_r3_s1", cap[3][6], 24'h00FF00);

    frame(2, 0, -1, -1);                       // F6: gradient, phase 1
    lit("grad_s3", cap[0][12], 24'h000300);

    mode = 2'd2; freeze = 1'b0;                // F7: gradient extremes, blanking, reset
    px(0, 0, 1);
    lit("grad_col0_valid", 24'(bus.pix_valid), 24'h1);
    px(10'h3FF, 0, 1);
    lit("grad_3ff", {bus.red, bus.green, bus.blue}, 24'h0000FF);
    px(10'h200, 0, 1);
    lit("grad_200", {bus.red, bus.green, bus.blue}, 24'h000080);
    px(5, 0, 0);
    lit("inactive_rgb", {bus.red, bus.green, bus.blue}, 24'h0);
    lit("inactive_valid", 24'(bus.pix_valid), 24'h0);
    px(6, 0, 1);
    reset_n = 1'b0;
    px(7, 0, 1);
    lit("midframe_reset_rgb", {bus.red, bus.green, bus.blue}, 24'h0);
    lit("midframe_reset_phase", 24'(phase), 24'h0);
    reset_n = 1'b1;

    for (int f = 0; f < 30; f++) begin
      int gap;
      gap = $urandom_range(0, 12);
      for (int i = 0; i < gap; i++) begin
        freeze = $urandom_range(0, 1) == 1;
        px(H_TOT, V_TOT, 0);
      end
      frame($urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 99)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
